// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         LEN_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // States in which the core must be held in reset.
  function automatic logic is_hold_state(input state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_loader_if;

  // A byte transfers on every cycle where rx_valid && rx_ready are both high;
  // rx_valid may drop between bytes for any number of cycles, and the loader
  // never deasserts rx_ready once out of reset. wr_en is a single-cycle strobe
  // with wr_addr/wr_data valid in the same cycle; there is no write back-pressure.
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  // Host side: UART receiver feeding bytes, instruction memory taking writes.
  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  // Loader side.
  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader writing little-endian words into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  imem_loader_if.slave     bus,
  output logic             cpu_hold,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] word_cnt,
  output state_t           dbg_state
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER_PAYLOAD = ST_CSUM;
`else
  localparam state_t ST_AFTER_PAYLOAD = ST_DONE;
`endif

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_rx_ready;
  logic [7:0]       r_len_lo;
  logic [LEN_W-1:0] r_len;
  logic [23:0]      r_shift;
  logic [1:0]       r_byte_cnt;
  logic             r_wr_en;
  logic [31:0]      r_wr_addr;
  logic [31:0]      r_wr_data;
  logic             r_cpu_hold;
  logic             r_done;
  logic             r_err;
  logic [LEN_W-1:0] r_word_cnt;

  logic [7:0]       w_len_lo_nxt;
  logic [LEN_W-1:0] w_len_nxt;
  logic [23:0]      w_shift_nxt;
  logic [1:0]       w_byte_cnt_nxt;
  logic             w_wr_en_nxt;
  logic [31:0]      w_wr_addr_nxt;
  logic [31:0]      w_wr_data_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic [LEN_W-1:0] w_word_cnt_nxt;

  logic             w_accept;
  logic             w_sync;
  logic             w_restart;
  logic [LEN_W-1:0] w_len_rx;
  logic             w_word_done;
  logic             w_last_word;

  assign w_accept    = bus.rx_valid && r_rx_ready;
  assign w_sync      = w_accept && (bus.rx_data == SYNC_BYTE);
  assign w_restart   = w_sync && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_len_rx    = {bus.rx_data, r_len_lo};
  assign w_word_done = w_accept && (r_state == ST_DATA) && (r_byte_cnt == 2'd3);
  assign w_last_word = (r_word_cnt + LEN_W'(1)) == r_len;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic [7:0] w_csum_nxt;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (w_sync) w_state_nxt = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_accept) w_state_nxt = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_accept) begin
          if ({16'd0, w_len_rx} > DEPTH_U) w_state_nxt = ST_ERR;
          else if (w_len_rx == '0)         w_state_nxt = ST_AFTER_PAYLOAD;
          else                             w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_word_done && w_last_word) w_state_nxt = ST_AFTER_PAYLOAD;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (w_accept) w_state_nxt = (bus.rx_data == r_csum) ? ST_DONE : ST_ERR;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    w_len_lo_nxt   = r_len_lo;
    w_len_nxt      = r_len;
    w_shift_nxt    = r_shift;
    w_byte_cnt_nxt = r_byte_cnt;
    w_wr_en_nxt    = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    w_done_nxt     = r_done;
    w_err_nxt      = r_err;
    w_word_cnt_nxt = r_word_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    w_csum_nxt     = r_csum;
`endif

    if (w_restart) begin
      w_done_nxt     = 1'b0;
      w_err_nxt      = 1'b0;
      w_word_cnt_nxt = '0;
      w_byte_cnt_nxt = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      w_csum_nxt     = 8'h00;
`endif
    end

    if (w_accept && (r_state == ST_LEN_LO)) w_len_lo_nxt = bus.rx_data;
    if (w_accept && (r_state == ST_LEN_HI)) begin
      w_len_nxt      = w_len_rx;
      w_byte_cnt_nxt = 2'd0;
    end

    // Bytes arrive LSB first, so each shifts in from the top.
    if (w_accept && (r_state == ST_DATA)) begin
      w_shift_nxt    = {bus.rx_data, r_shift[23:8]};
      w_byte_cnt_nxt = r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      w_csum_nxt     = r_csum ^ bus.rx_data;
`endif
      if (w_word_done) begin
        w_wr_en_nxt    = 1'b1;
        w_wr_data_nxt  = {bus.rx_data, r_shift};
        w_wr_addr_nxt  = BASE_ADDR + {14'd0, r_word_cnt, 2'b00};
        w_word_cnt_nxt = r_word_cnt + LEN_W'(1);
      end
    end

    if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE)) w_done_nxt = 1'b1;
    if ((w_state_nxt == ST_ERR)  && (r_state != ST_ERR))  w_err_nxt  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_ready <= 1'b0;
      r_len_lo   <= 8'h00;
      r_len      <= '0;
      r_shift    <= 24'h0;
      r_byte_cnt <= 2'd0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= BASE_ADDR;
      r_wr_data  <= 32'h0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_rx_ready <= 1'b1;
      r_len_lo   <= w_len_lo_nxt;
      r_len      <= w_len_nxt;
      r_shift    <= w_shift_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_cpu_hold <= is_hold_state(w_state_nxt);
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_word_cnt <= w_word_cnt_nxt;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) r_csum <= 8'h00;
    else     r_csum <= w_csum_nxt;
  end
`endif

  assign bus.rx_ready = r_rx_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign cpu_hold     = r_cpu_hold;
  assign done         = r_done;
  assign err          = r_err;
  assign word_cnt     = r_word_cnt;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized frames against a word-list reference model of the boot loader.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam logic [31:0] TB_BASE  = 32'h0000_0100;
  localparam int          TB_DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] word_cnt;
  state_t      dbg_state;

  imem_loader_if bus ();

  imem_loader #(
    .DEPTH_WORDS (TB_DEPTH),
    .BASE_ADDR   (TB_BASE)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err),
    .word_cnt  (word_cnt),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [31:0] pay_q[$];

  always @(negedge clk) begin
    if (bus.wr_en) obs_q.push_back({bus.wr_addr, bus.wr_data});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    @(negedge clk);
    #1;
    check({tag, "_wr_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_wr%0d", tag, i), (i < obs_q.size()) ? obs_q[i] : 64'hx, exp_q[i]);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // Sends pay_q as one frame and checks flags plus every write against the word list.
  task automatic send_frame(input string tag, input int max_gap, input int junk, input bit corrupt);
    logic [15:0] n;
    logic [7:0]  cs;
    logic [31:0] w;
    bit          exp_ok;
    n  = 16'(pay_q.size());
    cs = 8'h00;
    for (int j = 0; j < junk; j++) send_byte((j % 2 == 0) ? 8'h00 : 8'hFF, 0);
    send_byte(SYNC_BYTE, 0);
    check({tag, "_sync_done"}, 64'(done), 64'(0));
    check({tag, "_sync_err"},  64'(err),  64'(0));
    check({tag, "_sync_hold"}, 64'(cpu_hold), 64'(1));
    check({tag, "_sync_cnt"},  64'(word_cnt), 64'(0));
    send_byte(n[7:0], 0);
    send_byte(n[15:8], 0);
    for (int i = 0; i < pay_q.size(); i++) begin
      w = pay_q[i];
      for (int k = 0; k < 4; k++) begin
        cs ^= w[8*k +: 8];
        send_byte(w[8*k +: 8], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
      end
      exp_q.push_back({TB_BASE + 32'(4 * i), w});
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs ^ {7'd0, corrupt}, 0);
`endif
    exp_ok = !corrupt;
    check({tag, "_done"},  64'(done),     64'(exp_ok));
    check({tag, "_err"},   64'(err),      64'(!exp_ok));
    check({tag, "_hold"},  64'(cpu_hold), 64'(0));
    check({tag, "_cnt"},   64'(word_cnt), 64'(n));
    check({tag, "_state"}, 64'(dbg_state), exp_ok ? 64'(ST_DONE) : 64'(ST_ERR));
    check_writes(tag);
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] w0;
    logic [31:0] w1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 64'(bus.rx_ready), 64'(0));
    check("rst_wr_en",    64'(bus.wr_en),    64'(0));
    check("rst_wr_addr",  64'(bus.wr_addr),  64'(TB_BASE));
    check("rst_wr_data",  64'(bus.wr_data),  64'(0));
    check("rst_hold",     64'(cpu_hold),     64'(0));
    check("rst_done",     64'(done),         64'(0));
    check("rst_err",      64'(err),          64'(0));
    check("rst_cnt",      64'(word_cnt),     64'(0));
    check("rst_state",    64'(dbg_state),    64'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("rx_ready_rise", 64'(bus.rx_ready), 64'(1));

    // Two-word reference frame
    pay_q = '{32'h0000_0013, 32'h0010_0093};
    send_frame("frame_a", 0, 0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_frame("frame_a_badcs", 0, 0, 1'b1);
`endif
    // Same words with leading junk and gaps inside words
    send_frame("frame_a_gaps", 7, 2, 1'b0);

    // Oversized length: one past capacity
    send_byte(SYNC_BYTE, 0);
    check("big_sync_done", 64'(done), 64'(0));
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    check("big_err",   64'(err),       64'(1));
    check("big_done",  64'(done),      64'(0));
    check("big_hold",  64'(cpu_hold),  64'(0));
    check("big_state", 64'(dbg_state), 64'(ST_ERR));
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(255, 0));
      if (b == SYNC_BYTE) b = 8'h5A;
      send_byte(b, int'($urandom_range(2, 0)));
    end
    check("big_drop_state", 64'(dbg_state), 64'(ST_ERR));
    check("big_drop_err",   64'(err),       64'(1));
    check("big_drop_cnt",   64'(word_cnt),  64'(0));
    check_writes("big");

    // Randomized frames, first one empty
    for (int f = 0; f < 6; f++) begin
      pay_q.delete();
      for (int i = 0; i < ((f == 0) ? 0 : int'($urandom_range(8, 1))); i++) pay_q.push_back($urandom);
      send_frame($sformatf("rand%0d", f), int'($urandom_range(3, 0)), int'($urandom_range(2, 0)), 1'b0);
    end

    // Full-capacity frame
    pay_q.delete();
    for (int i = 0; i < TB_DEPTH; i++) pay_q.push_back($urandom);
    send_frame("full", 0, 0, 1'b0);

    // Reset after six payload bytes of a three-word frame
    w0 = $urandom;
    w1 = $urandom;
    send_byte(SYNC_BYTE, 0);
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8], 0);
    send_byte(w1[7:0], 0);
    send_byte(w1[15:8], 0);
    exp_q.push_back({TB_BASE, w0});
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_wr_en", 64'(bus.wr_en),    64'(0));
    check("mid_rst_state", 64'(dbg_state),    64'(ST_IDLE));
    check("mid_rst_hold",  64'(cpu_hold),     64'(0));
    check("mid_rst_done",  64'(done),         64'(0));
    check("mid_rst_cnt",   64'(word_cnt),     64'(0));
    check("mid_rst_ready", 64'(bus.rx_ready), 64'(0));
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_writes("mid_rst");

    // Clean frame after the reset
    pay_q = '{$urandom, $urandom, $urandom};
    send_frame("post_rst", 2, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
